// File: rtl/dual_clock_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Binary pointers carry one extra wrap bit so full and empty are distinguishable.
module dual_clock_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    localparam int ADDR_W  = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                          (wptr[ADDR_W] != rptr[ADDR_W]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Acceptance uses pre-edge flags, so a full FIFO never passes a write through.
    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            rdata     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rdata <= mem[rptr[ADDR_W-1:0]];
                rptr  <= rptr + 1'b1;
            end
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wptr[ADDR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Self-checking bench for dual_clock_fifo: queue scoreboard plus flag model,
// directed scenarios followed by random traffic.
module tb_dual_clock_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic [3:0]        count;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] m_rdata;
    logic              m_ovf;
    logic              m_unf;

    dual_clock_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .wdata        (wdata),
        .ren          (ren),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, update the model with pre-edge
    // state, then compare every output shortly after the rising edge.
    task automatic cycle(input logic r, input logic w, input logic [DATA_W-1:0] wd, input logic rd);
        int  n;
        bit  m_full;
        bit  m_empty;
        @(negedge clk);
        rst   = r;
        wen   = w;
        wdata = wd;
        ren   = rd;
        @(posedge clk);
        #1;
        m_full  = (sb_q.size() == DEPTH);
        m_empty = (sb_q.size() == 0);
        if (r) begin
            sb_q.delete();
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (rd && !m_empty) m_rdata = sb_q.pop_front();
            if (w && !m_full)   sb_q.push_back(wd);
            if (w && m_full)    m_ovf = 1'b1;
            if (rd && m_empty)  m_unf = 1'b1;
        end
        n = sb_q.size();
        chk("rdata",        32'(rdata),        32'(m_rdata));
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    logic [DATA_W-1:0] fill_pat [8];

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
        m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
        fill_pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);

        foreach (fill_pat[i]) cycle(0, 1, fill_pat[i], 0);
        chk("fill_full", 32'(full), 32'd1);

        cycle(0, 1, 8'h99, 0);
        cycle(0, 0, 8'h00, 0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
        chk("drain3_rdata", 32'(rdata), 32'h0C3);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1);
        chk("drain_last", 32'(rdata), 32'h018);
        cycle(0, 0, 8'h00, 1);
        chk("underflow_hold", 32'(rdata), 32'h018);

        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h50 + i), 1);
        chk("simul_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);

        cycle(0, 1, 8'h77, 1);
        chk("empty_wr_rd_cnt", 32'(count), 32'd1);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h60 + i), 0);
        cycle(0, 1, 8'hEE, 1);
        chk("full_wr_rd_cnt", 32'(count), 32'd7);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);

        cycle(1, 1, 8'h33, 1);
        chk("rst_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        while (sb_q.size() != 0) cycle(0, 0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
